lcd_controller: RTL and testbench
=================================

# lcd_controller

- Consumes the display command stream issued by BIOS and OS code (the `clear` opcode 100110 and the positioned character-write opcode 100111) and drives an HD44780-compatible 16x2 character LCD over its 8-bit parallel bus.
- Sits between the CPU's display-instruction execute path and the board LCD pins.
- Owns power-up initialisation, enable-pulse generation and all controller wait timing.
- The CPU only sees a valid/ready handshake.

## Interface
Parameters:
- EN_CYCLES, 25, width of lcd_en high pulse in clocks (≥450 ns at 50 MHz)
- CMD_WAIT, 2000, post-pulse wait for ordinary instructions/data (40 µs)
- CLEAR_WAIT, 82000, post-pulse wait for clear-display (1.64 ms)
- POWERUP_WAIT, 750000, idle time after reset before first init write (15 ms)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_clear  in  1  1 = clear display; 0 = write character
- cmd_pos  in  5  screen position 0–31 (0–15 line 1, 16–31 line 2)
- cmd_char  in  8  ASCII code to write
- cmd_ready  out  1  controller can accept a command
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  0 = instruction, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_en  out  1  LCD enable strobe
- lcd_on  out  1  LCD power/backlight enable

## Operation
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready. Inputs are sampled only at acceptance. cmd_ready is high only in IDLE.
- cmd_clear=1 takes priority; cmd_pos/cmd_char are ignored.
- Address map: pos<16 → DDRAM 0x00+pos; pos≥16 → 0x40+(pos−16). Set-address instruction = 0x80|addr.
- Bus transaction (TXN), three phases:
  - SETUP: 1 cycle, lcd_rs/lcd_data driven, lcd_en=0.
  - PULSE: EN_CYCLES cycles, lcd_en=1.
  - WAIT: wait count cycles, lcd_en=0.
  - lcd_data/lcd_rs hold stable through all three phases.
- States: POWERUP → INIT (4 TXNs) → IDLE ↔ {CLEAR, SET_ADDR → WRITE_DATA}.
  - POWERUP: count POWERUP_WAIT cycles.
  - INIT: rs=0 instructions 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear, CLEAR_WAIT), 0x06 (increment, no shift). All except 0x01 use CMD_WAIT.
  - CLEAR: one TXN, rs=0, data 0x01, CLEAR_WAIT.
  - SET_ADDR: rs=0, data 0x80|addr, CMD_WAIT.
  - WRITE_DATA: rs=1, data cmd_char, CMD_WAIT.
- Every state returns to IDLE after its final WAIT.
- Reset mid-operation: all outputs return to reset values immediately, and the FSM restarts at POWERUP. A partially written character is lost.
- Counters are sized to hold the largest parameter and do not wrap during a phase.

## Timing
- Reset values: cmd_ready=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcd_on=1.
- Let T(w) = 1+EN_CYCLES+w.
- cmd_ready rises POWERUP_WAIT + 3·T(CMD_WAIT) + T(CLEAR_WAIT) cycles after reset deassertion.
- cmd_ready falls on the edge after acceptance and stays low until the command's last WAIT cycle ends.
- Latencies measured from the acceptance edge to cmd_ready high:
  - character write: 2·T(CMD_WAIT) cycles (T(CMD_WAIT) when the address-set TXN is skipped; see Configuration)
  - clear: T(CLEAR_WAIT) cycles
- lcd_data/lcd_rs change only in SETUP, never while lcd_en=1.
- Back-to-back commands: a new command may be accepted on the same edge cmd_ready first reads high, with no bubble cycle.

## Configuration
- LCD_ADDR_SKIP_EN defined:
  - The controller tracks the LCD cursor.
  - Clear sets the tracked cursor to pos 0.
  - A data write at pos p sets it to p+1, except p=15 or p=31, which mark it invalid (hardware increments to a non-visible address).
  - Reset marks it invalid until INIT completes (INIT's clear sets pos 0).
  - If cmd_pos equals a valid tracked cursor, SET_ADDR is skipped.
- LCD_ADDR_SKIP_EN undefined: SET_ADDR always precedes WRITE_DATA and no cursor state exists.

## Test plan
All scenarios use overrides EN_CYCLES=2, CMD_WAIT=4, CLEAR_WAIT=10, POWERUP_WAIT=20, so T(CMD_WAIT)=7 and T(CLEAR_WAIT)=13.
- Init: release reset → four lcd_en pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0; cmd_ready rises exactly 54 cycles after release.
- Write 'B' (0x42) at pos 1, macro off → TXN 0x81 rs=0, then 0x42 rs=1; cmd_ready high 14 cycles after acceptance.
- Write at pos 16 then pos 31 → address bytes 0xC0 and 0xCF.
- Clear with cmd_clear=1, cmd_pos=5, cmd_char=0x41 → single TXN 0x01 rs=0 and no data write; cmd_ready after 13 cycles.
- LCD_ADDR_SKIP_EN defined:
  - write pos 0 then pos 1 → second write has no SET_ADDR and cmd_ready returns after 7 cycles;
  - write pos 15 then pos 16 → second write emits 0xC0.
- Assert reset during the PULSE of a data write → lcd_en=0 and cmd_ready=0 immediately; full init sequence replays after release.

Source files
------------

// File: rtl/lcd_controller.sv
// HD44780 16x2 character LCD controller: power-up init, enable strobes and wait timing.
// Optional LCD_ADDR_SKIP_EN tracks the LCD cursor and omits redundant set-address writes.
module lcd_controller #(
    parameter int EN_CYCLES    = 25,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int POWERUP_WAIT = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_clear,
    input  logic [4:0] cmd_pos,
    input  logic [7:0] cmd_char,
    output logic       cmd_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic [4:0] dbg_state_o
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_* inputs are sampled only on that edge and cmd_ready is high only in IDLE.

    localparam int MAX_A   = (EN_CYCLES > CMD_WAIT) ? EN_CYCLES : CMD_WAIT;
    localparam int MAX_B   = (CLEAR_WAIT > POWERUP_WAIT) ? CLEAR_WAIT : POWERUP_WAIT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT - 1);
    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_WAIT - 1);

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT, S_IDLE, S_CLEAR, S_SET_ADDR, S_WRITE_DATA
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP, P_PULSE, P_WAIT
    } phase_t;

    state_t        state_q;
    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    init_idx_q;
    logic [7:0]    char_q;
    logic          cmd_ready_q;
    logic [7:0]    lcd_data_q;
    logic          lcd_rs_q;
    logic          lcd_en_q;
    logic          lcd_on_q;

    logic          is_clear_txn;
    logic [CW-1:0] wait_last;
    logic          txn_done;
    logic          accept;
    logic [7:0]    addr_byte;
    logic          skip_addr;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // The clear instruction is recognised from the bus itself so INIT and CLEAR share it.
    assign is_clear_txn = !lcd_rs_q && (lcd_data_q == 8'h01);
    assign wait_last    = is_clear_txn ? CLR_LAST : CMD_LAST;
    assign txn_done     = (state_q != S_POWERUP) && (state_q != S_IDLE) &&
                          (phase_q == P_WAIT) && (cnt_q == wait_last);
    assign accept       = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    // Line 1 maps to 0x00+pos, line 2 to 0x40+(pos-16); bit 4 of pos selects the line.
    assign addr_byte    = {1'b1, cmd_pos[4], 2'b00, cmd_pos[3:0]};

`ifdef LCD_ADDR_SKIP_EN
    logic [4:0] cur_q;
    logic       cur_ok_q;
    logic [4:0] pos_q;

    assign skip_addr = cur_ok_q && (cur_q == cmd_pos);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q    <= 5'd0;
            cur_ok_q <= 1'b0;
            pos_q    <= 5'd0;
        end else begin
            if (accept) begin
                pos_q <= cmd_pos;
            end
            if (txn_done && is_clear_txn) begin
                cur_q    <= 5'd0;
                cur_ok_q <= 1'b1;
            end else if (txn_done && (state_q == S_WRITE_DATA)) begin
                // Past the end of a line the LCD cursor lands on a non-visible address.
                if (pos_q[3:0] == 4'hF) begin
                    cur_ok_q <= 1'b0;
                end else begin
                    cur_q    <= pos_q + 5'd1;
                    cur_ok_q <= 1'b1;
                end
            end
        end
    end
`else
    assign skip_addr = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_POWERUP;
            phase_q     <= P_SETUP;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            char_q      <= 8'h00;
            cmd_ready_q <= 1'b0;
            lcd_data_q  <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_on_q    <= 1'b1;
        end else begin
            lcd_on_q <= 1'b1;
            case (state_q)
                S_POWERUP: begin
                    if (cnt_q == PWR_LAST) begin
                        cnt_q      <= '0;
                        state_q    <= S_INIT;
                        phase_q    <= P_SETUP;
                        init_idx_q <= 2'd0;
                        lcd_data_q <= init_byte(2'd0);
                        lcd_rs_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        phase_q     <= P_SETUP;
                        cnt_q       <= '0;
                        char_q      <= cmd_char;
                        if (cmd_clear) begin
                            state_q    <= S_CLEAR;
                            lcd_data_q <= 8'h01;
                            lcd_rs_q   <= 1'b0;
                        end else if (skip_addr) begin
                            state_q    <= S_WRITE_DATA;
                            lcd_data_q <= cmd_char;
                            lcd_rs_q   <= 1'b1;
                        end else begin
                            state_q    <= S_SET_ADDR;
                            lcd_data_q <= addr_byte;
                            lcd_rs_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    case (phase_q)
                        P_SETUP: begin
                            phase_q  <= P_PULSE;
                            lcd_en_q <= 1'b1;
                            cnt_q    <= '0;
                        end
                        P_PULSE: begin
                            if (cnt_q == EN_LAST) begin
                                phase_q  <= P_WAIT;
                                lcd_en_q <= 1'b0;
                                cnt_q    <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        P_WAIT: begin
                            if (cnt_q == wait_last) begin
                                cnt_q   <= '0;
                                phase_q <= P_SETUP;
                                if (state_q == S_INIT && init_idx_q != 2'd3) begin
                                    init_idx_q <= init_idx_q + 2'd1;
                                    lcd_data_q <= init_byte(init_idx_q + 2'd1);
                                    lcd_rs_q   <= 1'b0;
                                end else if (state_q == S_SET_ADDR) begin
                                    state_q    <= S_WRITE_DATA;
                                    lcd_data_q <= char_q;
                                    lcd_rs_q   <= 1'b1;
                                end else begin
                                    state_q     <= S_IDLE;
                                    cmd_ready_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            phase_q <= P_SETUP;
                        end
                    endcase
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign lcd_data    = lcd_data_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_en      = lcd_en_q;
    assign lcd_on      = lcd_on_q;
    assign dbg_state_o = {state_q, phase_q};

endmodule

// File: tb/tb_lcd_controller.sv
// Randomised scoreboard bench for lcd_controller with a transaction-level reference model.
module tb_lcd_controller;

    localparam int EN  = 2;
    localparam int CMW = 4;
    localparam int CLW = 10;
    localparam int PW  = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_clear = 1'b0;
    logic [4:0] cmd_pos = 5'd0;
    logic [7:0] cmd_char = 8'h00;
    logic       cmd_ready;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic [4:0] dbg_state;

    lcd_controller #(
        .EN_CYCLES(EN), .CMD_WAIT(CMW), .CLEAR_WAIT(CLW), .POWERUP_WAIT(PW)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_clear(cmd_clear),
        .cmd_pos(cmd_pos), .cmd_char(cmd_char), .cmd_ready(cmd_ready),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    int model_cur;
    bit model_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: whole transactions and latencies from the command rules
    function automatic int t_of(input int w);
        return 1 + EN + w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        model_cur = 0;
        model_ok  = 1'b1;
    endtask

    task automatic model_cmd(input bit clr, input logic [4:0] pos, input logic [7:0] ch,
                             output int lat);
        int p;
        bit skip;
        logic [7:0] addr;
        p = int'(pos);
        lat = 0;
        if (clr) begin
            exp_q.push_back(9'h001);
            lat = t_of(CLW);
            model_cur = 0;
            model_ok  = 1'b1;
        end else begin
            skip = 1'b0;
`ifdef LCD_ADDR_SKIP_EN
            skip = model_ok && (model_cur == p);
`endif
            if (!skip) begin
                addr = (p < 16) ? 8'(128 + p) : 8'(192 + p - 16);
                exp_q.push_back({1'b0, addr});
                lat += t_of(CMW);
            end
            exp_q.push_back({1'b1, ch});
            lat += t_of(CMW);
            if (p == 15 || p == 31) begin
                model_ok = 1'b0;
            end else begin
                model_cur = p + 1;
                model_ok  = 1'b1;
            end
        end
    endtask

    // monitor: pops the scoreboard on every enable pulse and checks pulse shape
    initial begin
        bit prev;
        int len;
        logic [8:0] cap;
        prev = 1'b0;
        len  = 0;
        cap  = 9'h000;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev = 1'b0;
                len  = 0;
            end else begin
                if (lcd_en && !prev) begin
                    cap = {lcd_rs, lcd_data};
                    len = 1;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_txn: got 0x%0h, expected no transaction", cap);
                    end else begin
                        check("txn_byte", 32'(cap), 32'(exp_q.pop_front()));
                    end
                end else if (lcd_en && prev) begin
                    len++;
                    check("bus_stable", 32'({lcd_rs, lcd_data}), 32'(cap));
                end else if (!lcd_en && prev) begin
                    check("pulse_width", len, EN);
                end
                prev = lcd_en;
            end
        end
    end

    // driver tasks
    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, cmd_ready, 0);
        check({tag, "_en"}, lcd_en, 0);
        check({tag, "_rs"}, lcd_rs, 0);
        check({tag, "_rw"}, lcd_rw, 0);
        check({tag, "_data"}, lcd_data, 0);
        check({tag, "_on"}, lcd_on, 1);
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("rst");
        model_reset();
        reset = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("init_latency", n, PW + 3 * t_of(CMW) + t_of(CLW));
        check("init_drain", exp_q.size(), 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", cmd_ready, 1);
    endtask

    task automatic send(input bit clr, input logic [4:0] pos, input logic [7:0] ch);
        int lat;
        int n;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_clear = clr;
        cmd_pos   = pos;
        cmd_char  = ch;
        model_cmd(clr, pos, ch, lat);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_clear = 1'($urandom_range(0, 1));
        cmd_pos   = 5'($urandom_range(0, 31));
        cmd_char  = 8'($urandom_range(0, 255));
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check(clr ? "clear_latency" : "write_latency", n, lat);
        check("cmd_drain", exp_q.size(), 0);
    endtask

    task automatic reset_mid_pulse();
        int lat;
        int n;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_clear = 1'b0;
        cmd_pos   = 5'($urandom_range(0, 31));
        cmd_char  = 8'($urandom_range(32, 126));
        model_cmd(1'b0, cmd_pos, cmd_char, lat);
        @(negedge clock);
        cmd_valid = 1'b0;
        n = 0;
        while (!(lcd_en && lcd_rs) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reached_data_pulse", 32'(lcd_en && lcd_rs), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_en", lcd_en, 0);
        check("midrst_ready", cmd_ready, 0);
        check("midrst_data", lcd_data, 0);
        do_reset();
    endtask

    initial begin
        bit clr;
        logic [4:0] pos;
        do_reset();
        send(1'b1, 5'd5, 8'h41);
        send(1'b0, 5'd1, 8'h42);
        send(1'b0, 5'd16, 8'h43);
        send(1'b0, 5'd31, 8'h44);
        send(1'b0, 5'd0, 8'h45);
        send(1'b0, 5'd1, 8'h46);
        send(1'b0, 5'd15, 8'h47);
        send(1'b0, 5'd16, 8'h48);
        for (int i = 0; i < 40; i++) begin
            clr = ($urandom_range(0, 5) == 0);
            pos = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) pos = 5'(model_cur);
            send(clr, pos, 8'($urandom_range(0, 255)));
        end
        reset_mid_pulse();
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
